// File: rtl/reorder_buffer_mp.sv
// Reorder buffer with multi-port operand reads, multi-channel CDB writeback,
// partial/full flush and up to COMMIT_W in-order commits per cycle.
// Each entry holds {station_id, valid, ready, dst_reg, opcode, content}. That
// is also the packed layout of each o_commit_data slot, MSB first.
module reorder_buffer_mp #(
    parameter int N_ROB_W    = 3,
    parameter int ROB_PORT_W = 6,
    parameter int N_CDB      = 2,
    parameter int COMMIT_W   = 2,
    parameter int REG_ADDR_W = 5,
    parameter int INSTR_W    = 8,
    parameter int DATA_W     = 32
) (
    input  logic                                                        clk,
    input  logic                                                        nrst,
    input  logic                                                        i_valid,
    output logic                                                        i_ready,
    output logic [N_ROB_W-1:0]                                          i_rsv_id,
    input  logic [REG_ADDR_W-1:0]                                       i_dst_reg,
    input  logic                                                        i_no_wait,
    input  logic [INSTR_W-1:0]                                          i_opcode,
    input  logic [ROB_PORT_W-1:0][N_ROB_W-1:0]                          rob_id,
    output logic [ROB_PORT_W-1:0][N_ROB_W+DATA_W-1:0]                   rob_data,
    output logic [ROB_PORT_W-1:0]                                       rob_data_filled,
    input  logic [N_CDB-1:0]                                            cdb_valid,
    input  logic [N_CDB-1:0][N_ROB_W+DATA_W-1:0]                        cdb,
    input  logic                                                        rob_clear,
    input  logic                                                        flush_valid,
    input  logic [N_ROB_W-1:0]                                          flush_id,
    output logic [COMMIT_W-1:0]                                         o_valid,
    output logic [COMMIT_W-1:0][N_ROB_W+2+REG_ADDR_W+INSTR_W+DATA_W-1:0] o_commit_data,
    input  logic [COMMIT_W-1:0]                                         o_ready,
    output logic [N_ROB_W:0]                                            o_count
);

    localparam int D = 1 << N_ROB_W;

    logic [N_ROB_W-1:0]    ent_id_reg    [D];
    logic                  ent_valid_reg [D];
    logic                  ent_ready_reg [D];
    logic [REG_ADDR_W-1:0] ent_dst_reg   [D];
    logic [INSTR_W-1:0]    ent_op_reg    [D];
    logic [DATA_W-1:0]     ent_data_reg  [D];

    logic [N_ROB_W-1:0]    ent_id_next    [D];
    logic                  ent_valid_next [D];
    logic                  ent_ready_next [D];
    logic [REG_ADDR_W-1:0] ent_dst_next   [D];
    logic [INSTR_W-1:0]    ent_op_next    [D];
    logic [DATA_W-1:0]     ent_data_next  [D];

    logic [N_ROB_W-1:0] head_reg, head_next;
    logic [N_ROB_W-1:0] tail_reg, tail_next;
    logic [N_ROB_W:0]   count_reg, count_next;

    logic               full;
    logic               dispatch;
    logic               flush_ok;
    logic [N_ROB_W-1:0] keep_off;
    logic [COMMIT_W-1:0] commit_mask;
    logic [N_ROB_W:0]   n_commit;

    // Dispatch is gated only by registered state and the flush inputs, never by o_ready.
    assign full     = (count_reg == (N_ROB_W+1)'(D));
    assign i_ready  = !full && !rob_clear && !flush_valid;
    assign i_rsv_id = tail_reg;
    assign dispatch = i_valid && i_ready;
    assign o_count  = count_reg;

    // A partial flush only takes effect when its anchor entry is live.
    assign flush_ok = flush_valid && !rob_clear && ent_valid_reg[flush_id];
    assign keep_off = flush_id - head_reg;

    // In-order commit window: each slot needs every older slot committable too.
    always_comb begin : commit_window
        logic vprev;
        logic run;
        vprev       = 1'b1;
        run         = 1'b1;
        n_commit    = '0;
        o_valid     = '0;
        commit_mask = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            o_valid[k] = vprev
                       && ent_valid_reg[head_reg + N_ROB_W'(k)]
                       && ent_ready_reg[head_reg + N_ROB_W'(k)]
                       && ((N_ROB_W+1)'(k) < count_reg)
                       && !rob_clear && !flush_valid;
            vprev          = o_valid[k];
            run            = run && o_valid[k] && o_ready[k];
            commit_mask[k] = run;
            if (run) begin
                n_commit = n_commit + (N_ROB_W+1)'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < COMMIT_W; gi++) begin : g_commit
            logic [N_ROB_W-1:0] slot;
            assign slot = head_reg + N_ROB_W'(gi);
            assign o_commit_data[gi] = {ent_id_reg[slot], ent_valid_reg[slot], ent_ready_reg[slot],
                                        ent_dst_reg[slot], ent_op_reg[slot], ent_data_reg[slot]};
        end

        for (gi = 0; gi < ROB_PORT_W; gi++) begin : g_read
            logic [DATA_W-1:0] fwd_data;
            logic              fwd_fill;
            // Operand read with same-cycle CDB bypass; the highest channel wins.
            always_comb begin
                fwd_data = ent_data_reg[rob_id[gi]];
                fwd_fill = ent_ready_reg[rob_id[gi]];
                for (int k = 0; k < N_CDB; k++) begin
                    if (cdb_valid[k] && (cdb[k][DATA_W +: N_ROB_W] == rob_id[gi])) begin
                        fwd_data = cdb[k][DATA_W-1:0];
                        fwd_fill = 1'b1;
                    end
                end
            end
            assign rob_data[gi]        = {rob_id[gi], fwd_data};
            assign rob_data_filled[gi] = fwd_fill;
        end
    endgenerate

    // Next-state: writeback, then allocation, then commit/flush/clear kills on top.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            ent_id_next[i]    = ent_id_reg[i];
            ent_valid_next[i] = ent_valid_reg[i];
            ent_ready_next[i] = ent_ready_reg[i];
            ent_dst_next[i]   = ent_dst_reg[i];
            ent_op_next[i]    = ent_op_reg[i];
            ent_data_next[i]  = ent_data_reg[i];
        end
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;

        if (rob_clear) begin
            for (int i = 0; i < D; i++) begin
                ent_id_next[i]    = '0;
                ent_valid_next[i] = 1'b0;
                ent_ready_next[i] = 1'b0;
                ent_dst_next[i]   = '0;
                ent_op_next[i]    = '0;
                ent_data_next[i]  = '0;
            end
            tail_next  = head_reg;
            count_next = '0;
        end else begin
            for (int k = 0; k < N_CDB; k++) begin
                if (cdb_valid[k] && ent_valid_reg[cdb[k][DATA_W +: N_ROB_W]]) begin
                    ent_ready_next[cdb[k][DATA_W +: N_ROB_W]] = 1'b1;
                    ent_data_next[cdb[k][DATA_W +: N_ROB_W]]  = cdb[k][DATA_W-1:0];
                end
            end
            if (dispatch) begin
                ent_id_next[tail_reg]    = tail_reg;
                ent_valid_next[tail_reg] = 1'b1;
                ent_ready_next[tail_reg] = i_no_wait;
                ent_dst_next[tail_reg]   = i_dst_reg;
                ent_op_next[tail_reg]    = i_opcode;
                ent_data_next[tail_reg]  = '0;
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (commit_mask[k]) begin
                    ent_id_next[head_reg + N_ROB_W'(k)]    = '0;
                    ent_valid_next[head_reg + N_ROB_W'(k)] = 1'b0;
                    ent_ready_next[head_reg + N_ROB_W'(k)] = 1'b0;
                    ent_dst_next[head_reg + N_ROB_W'(k)]   = '0;
                    ent_op_next[head_reg + N_ROB_W'(k)]    = '0;
                    ent_data_next[head_reg + N_ROB_W'(k)]  = '0;
                end
            end
            if (flush_ok) begin
                for (int i = 0; i < D; i++) begin
                    if ((N_ROB_W'(i) - head_reg) > keep_off) begin
                        ent_id_next[i]    = '0;
                        ent_valid_next[i] = 1'b0;
                        ent_ready_next[i] = 1'b0;
                        ent_dst_next[i]   = '0;
                        ent_op_next[i]    = '0;
                        ent_data_next[i]  = '0;
                    end
                end
                tail_next  = flush_id + N_ROB_W'(1);
                count_next = {1'b0, keep_off} + (N_ROB_W+1)'(1);
            end else begin
                tail_next  = dispatch ? tail_reg + N_ROB_W'(1) : tail_reg;
                count_next = count_reg + (N_ROB_W+1)'(dispatch) - n_commit;
            end
            head_next = head_reg + n_commit[N_ROB_W-1:0];
        end
    end

    // State registers with asynchronous clear of every entry and pointer.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < D; i++) begin
                ent_id_reg[i]    <= '0;
                ent_valid_reg[i] <= 1'b0;
                ent_ready_reg[i] <= 1'b0;
                ent_dst_reg[i]   <= '0;
                ent_op_reg[i]    <= '0;
                ent_data_reg[i]  <= '0;
            end
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            for (int i = 0; i < D; i++) begin
                ent_id_reg[i]    <= ent_id_next[i];
                ent_valid_reg[i] <= ent_valid_next[i];
                ent_ready_reg[i] <= ent_ready_next[i];
                ent_dst_reg[i]   <= ent_dst_next[i];
                ent_op_reg[i]    <= ent_op_next[i];
                ent_data_reg[i]  <= ent_data_next[i];
            end
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_reorder_buffer_mp.sv
// Scenario bench for reorder_buffer_mp: dispatches are pushed to a commit
// scoreboard and popped/compared as the DUT retires them.
module tb_reorder_buffer_mp;

    localparam int N  = 3;
    localparam int P  = 6;
    localparam int NC = 2;
    localparam int CW = 2;
    localparam int RW = 5;
    localparam int IW = 8;
    localparam int DW = 32;
    localparam int SW = N + 2 + RW + IW + DW;

    logic                       clk;
    logic                       nrst;
    logic                       i_valid;
    logic                       i_ready;
    logic [N-1:0]               i_rsv_id;
    logic [RW-1:0]              i_dst_reg;
    logic                       i_no_wait;
    logic [IW-1:0]              i_opcode;
    logic [P-1:0][N-1:0]        rob_id;
    logic [P-1:0][N+DW-1:0]     rob_data;
    logic [P-1:0]               rob_data_filled;
    logic [NC-1:0]              cdb_valid;
    logic [NC-1:0][N+DW-1:0]    cdb;
    logic                       rob_clear;
    logic                       flush_valid;
    logic [N-1:0]               flush_id;
    logic [CW-1:0]              o_valid;
    logic [CW-1:0][SW-1:0]      o_commit_data;
    logic [CW-1:0]              o_ready;
    logic [N:0]                 o_count;

    reorder_buffer_mp #(
        .N_ROB_W(N), .ROB_PORT_W(P), .N_CDB(NC), .COMMIT_W(CW),
        .REG_ADDR_W(RW), .INSTR_W(IW), .DATA_W(DW)
    ) dut (
        .clk(clk), .nrst(nrst),
        .i_valid(i_valid), .i_ready(i_ready), .i_rsv_id(i_rsv_id),
        .i_dst_reg(i_dst_reg), .i_no_wait(i_no_wait), .i_opcode(i_opcode),
        .rob_id(rob_id), .rob_data(rob_data), .rob_data_filled(rob_data_filled),
        .cdb_valid(cdb_valid), .cdb(cdb),
        .rob_clear(rob_clear), .flush_valid(flush_valid), .flush_id(flush_id),
        .o_valid(o_valid), .o_commit_data(o_commit_data), .o_ready(o_ready),
        .o_count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  id;
        logic [RW-1:0] dst;
        logic [IW-1:0] op;
    } sb_t;

    sb_t          sb[$];
    logic [DW-1:0] m_data  [8];
    logic          m_valid [8];
    logic [N-1:0]  m_head;
    logic [N-1:0]  m_tail;
    int            tests;
    int            fails;

    function automatic logic [SW-1:0] expected_commit();
        return {sb[0].id, 1'b1, 1'b1, sb[0].dst, sb[0].op, m_data[sb[0].id]};
    endfunction

    task automatic idle_inputs();
        i_valid = 0; i_dst_reg = '0; i_no_wait = 0; i_opcode = '0;
        rob_id = '0; cdb_valid = '0; cdb = '0;
        rob_clear = 0; flush_valid = 0; flush_id = '0; o_ready = '0;
    endtask

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            m_data[i] = '0;
            m_valid[i] = 1'b0;
        end
        m_head = '0;
        m_tail = '0;
    endtask

    task automatic apply_reset();
        nrst = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1;
    endtask

    task automatic drive_dispatch(input logic [RW-1:0] dst, input logic [IW-1:0] op,
                                  input logic nw, output logic [N-1:0] got);
        @(negedge clk);
        i_valid = 1; i_dst_reg = dst; i_opcode = op; i_no_wait = nw;
        #1 got = i_rsv_id;
        sb.push_back('{id: m_tail, dst: dst, op: op});
        m_valid[m_tail] = 1'b1;
        m_data[m_tail] = '0;
        m_tail = m_tail + 1'b1;
        @(posedge clk);
        #1 i_valid = 0;
    endtask

    task automatic drive_cdb(input logic [1:0] v, input logic [N-1:0] id0, input logic [DW-1:0] d0,
                             input logic [N-1:0] id1, input logic [DW-1:0] d1);
        @(negedge clk);
        cdb_valid = v;
        cdb[0] = {id0, d0};
        cdb[1] = {id1, d1};
        if (v[0] && m_valid[id0]) m_data[id0] = d0;
        if (v[1] && m_valid[id1]) m_data[id1] = d1;
        @(posedge clk);
        #1 cdb_valid = '0;
    endtask

    task automatic drive_commit(input logic [1:0] rdy, output logic [1:0] ov,
                                output logic [SW-1:0] cd0, output logic [SW-1:0] cd1);
        @(negedge clk);
        o_ready = rdy;
        #1;
        ov  = o_valid;
        cd0 = o_commit_data[0];
        cd1 = o_commit_data[1];
        @(posedge clk);
        #1 o_ready = '0;
    endtask

    task automatic test_reset();
        tests++; if (o_valid !== 2'b00) begin fails++; $display("FAIL reset_o_valid got=%b exp=00", o_valid); end
        tests++; if (i_ready !== 1'b1) begin fails++; $display("FAIL reset_i_ready got=%b exp=1", i_ready); end
        tests++; if (i_rsv_id !== 3'd0) begin fails++; $display("FAIL reset_rsv_id got=%0d exp=0", i_rsv_id); end
        tests++; if (o_count !== 4'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        tests++; if (rob_data_filled !== 6'b0) begin fails++; $display("FAIL reset_filled got=%b exp=0", rob_data_filled); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_fill_wrap();
        logic [N-1:0] got;
        logic [1:0] ov;
        logic [SW-1:0] cd0, cd1;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive_dispatch(RW'(i), IW'(8'h10 + i), 1'b0, got);
            tests++; if (got !== N'(i)) begin fails++; $display("FAIL fill_id got=%0d exp=%0d", got, i); end
        end
        @(negedge clk); #1;
        tests++; if (i_ready !== 1'b0) begin fails++; $display("FAIL full_i_ready got=%b exp=0", i_ready); end
        tests++; if (o_count !== 4'd8) begin fails++; $display("FAIL full_count got=%0d exp=8", o_count); end
        drive_cdb(2'b11, 3'd0, 32'h100, 3'd1, 32'h101);
        drive_commit(2'b11, ov, cd0, cd1);
        tests++; if (ov !== 2'b11) begin fails++; $display("FAIL wrap_o_valid got=%b exp=11", ov); end
        tests++; if (cd0 !== expected_commit()) begin fails++; $display("FAIL wrap_commit0 got=%h exp=%h", cd0, expected_commit()); end
        void'(sb.pop_front()); m_valid[m_head] = 0; m_head++;
        tests++; if (cd1 !== expected_commit()) begin fails++; $display("FAIL wrap_commit1 got=%h exp=%h", cd1, expected_commit()); end
        void'(sb.pop_front()); m_valid[m_head] = 0; m_head++;
        tests++; if (o_count !== 4'd6) begin fails++; $display("FAIL wrap_count got=%0d exp=6", o_count); end
        tests++; if (i_rsv_id !== m_tail) begin fails++; $display("FAIL wrap_rsv_id got=%0d exp=%0d", i_rsv_id, m_tail); end
        tests++; if (i_ready !== 1'b1) begin fails++; $display("FAIL wrap_i_ready got=%b exp=1", i_ready); end
        $display("[TB] test_fill_wrap done head=%0d tail=%0d", m_head, m_tail);
    endtask

    task automatic test_in_order_stall();
        logic [N-1:0] got;
        logic [1:0] ov;
        logic [SW-1:0] cd0, cd1;
        apply_reset();
        drive_dispatch(5'd3, 8'h21, 1'b0, got);
        drive_dispatch(5'd4, 8'h22, 1'b0, got);
        drive_cdb(2'b01, 3'd1, 32'h55, 3'd0, 32'h0);
        @(negedge clk); #1;
        tests++; if (o_valid !== 2'b00) begin fails++; $display("FAIL stall_o_valid got=%b exp=00", o_valid); end
        drive_cdb(2'b01, 3'd0, 32'h44, 3'd0, 32'h0);
        drive_commit(2'b11, ov, cd0, cd1);
        tests++; if (ov !== 2'b11) begin fails++; $display("FAIL stall_release got=%b exp=11", ov); end
        tests++; if (cd0 !== expected_commit()) begin fails++; $display("FAIL stall_commit0 got=%h exp=%h", cd0, expected_commit()); end
        void'(sb.pop_front()); m_valid[m_head] = 0; m_head++;
        tests++; if (cd1 !== expected_commit()) begin fails++; $display("FAIL stall_commit1 got=%h exp=%h", cd1, expected_commit()); end
        void'(sb.pop_front()); m_valid[m_head] = 0; m_head++;
        tests++; if (o_count !== 4'd0) begin fails++; $display("FAIL stall_count got=%0d exp=0", o_count); end
        $display("[TB] test_in_order_stall done");
    endtask

    task automatic test_partial_commit();
        logic [N-1:0] got;
        logic [1:0] ov;
        logic [SW-1:0] cd0, cd1;
        apply_reset();
        drive_dispatch(5'd7, 8'h31, 1'b1, got);
        drive_dispatch(5'd8, 8'h32, 1'b1, got);
        drive_commit(2'b10, ov, cd0, cd1);
        tests++; if (ov !== 2'b11) begin fails++; $display("FAIL pc_o_valid got=%b exp=11", ov); end
        tests++; if (o_count !== 4'd2) begin fails++; $display("FAIL pc_none_count got=%0d exp=2", o_count); end
        drive_commit(2'b01, ov, cd0, cd1);
        tests++; if (cd0 !== expected_commit()) begin fails++; $display("FAIL pc_commit0 got=%h exp=%h", cd0, expected_commit()); end
        void'(sb.pop_front()); m_valid[m_head] = 0; m_head++;
        tests++; if (o_count !== 4'd1) begin fails++; $display("FAIL pc_one_count got=%0d exp=1", o_count); end
        @(negedge clk); #1;
        tests++; if (o_valid !== 2'b01) begin fails++; $display("FAIL pc_head_valid got=%b exp=01", o_valid); end
        tests++; if (o_commit_data[0] !== expected_commit()) begin fails++; $display("FAIL pc_head_data got=%h exp=%h", o_commit_data[0], expected_commit()); end
        $display("[TB] test_partial_commit done head=%0d", m_head);
    endtask

    task automatic test_partial_flush();
        logic [N-1:0] got;
        apply_reset();
        for (int i = 0; i < 6; i++) drive_dispatch(RW'(i), IW'(8'h40 + i), 1'b0, got);
        @(negedge clk);
        flush_valid = 1; flush_id = 3'd2;
        #1;
        tests++; if (i_ready !== 1'b0) begin fails++; $display("FAIL flush_i_ready got=%b exp=0", i_ready); end
        @(posedge clk);
        #1 flush_valid = 0;
        while (sb.size() > 3) begin
            m_valid[sb[sb.size()-1].id] = 1'b0;
            void'(sb.pop_back());
        end
        m_tail = 3'd3;
        tests++; if (o_count !== 4'd3) begin fails++; $display("FAIL flush_count got=%0d exp=3", o_count); end
        tests++; if (i_rsv_id !== 3'd3) begin fails++; $display("FAIL flush_tail got=%0d exp=3", i_rsv_id); end
        drive_cdb(2'b01, 3'd4, 32'h77, 3'd0, 32'h0);
        @(negedge clk);
        rob_id[0] = 3'd4;
        #1;
        tests++; if (rob_data_filled[0] !== 1'b0) begin fails++; $display("FAIL flush_late_cdb got=%b exp=0", rob_data_filled[0]); end
        tests++; if (rob_data[0] !== {3'd4, 32'h0}) begin fails++; $display("FAIL flush_late_data got=%h exp=%h", rob_data[0], {3'd4, 32'h0}); end
        drive_dispatch(5'd9, 8'h50, 1'b0, got);
        tests++; if (got !== 3'd3) begin fails++; $display("FAIL flush_next_id got=%0d exp=3", got); end
        $display("[TB] test_partial_flush done");
    endtask

    task automatic test_forwarding();
        logic [N-1:0] got;
        apply_reset();
        for (int i = 0; i < 4; i++) drive_dispatch(RW'(i), IW'(8'h60 + i), 1'b0, got);
        @(negedge clk);
        cdb_valid = 2'b11;
        cdb[0] = {3'd3, 32'hA};
        cdb[1] = {3'd3, 32'hB};
        rob_id[0] = 3'd3;
        rob_id[1] = 3'd2;
        m_data[3] = 32'hB;
        #1;
        tests++; if (rob_data[0] !== {3'd3, 32'hB}) begin fails++; $display("FAIL fwd_data got=%h exp=%h", rob_data[0], {3'd3, 32'hB}); end
        tests++; if (rob_data_filled[1:0] !== 2'b01) begin fails++; $display("FAIL fwd_filled got=%b exp=01", rob_data_filled[1:0]); end
        @(posedge clk);
        #1 cdb_valid = '0;
        #1;
        tests++; if (rob_data[0] !== {3'd3, m_data[3]}) begin fails++; $display("FAIL fwd_stored got=%h exp=%h", rob_data[0], {3'd3, m_data[3]}); end
        tests++; if (rob_data_filled[0] !== 1'b1) begin fails++; $display("FAIL fwd_stored_fill got=%b exp=1", rob_data_filled[0]); end
        $display("[TB] test_forwarding done");
    endtask

    task automatic test_async_reset();
        logic [N-1:0] got;
        apply_reset();
        for (int i = 0; i < 5; i++) drive_dispatch(RW'(i), IW'(8'h70 + i), 1'b1, got);
        @(negedge clk); #1;
        tests++; if (o_count !== 4'd5) begin fails++; $display("FAIL ar_pre_count got=%0d exp=5", o_count); end
        tests++; if (o_valid !== 2'b11) begin fails++; $display("FAIL ar_pre_valid got=%b exp=11", o_valid); end
        #2 nrst = 0;
        #1;
        tests++; if (o_count !== 4'd0) begin fails++; $display("FAIL ar_count got=%0d exp=0", o_count); end
        tests++; if (o_valid !== 2'b00) begin fails++; $display("FAIL ar_valid got=%b exp=00", o_valid); end
        tests++; if (i_ready !== 1'b1) begin fails++; $display("FAIL ar_i_ready got=%b exp=1", i_ready); end
        model_reset();
        @(negedge clk);
        nrst = 1;
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_rob_clear();
        logic [N-1:0] got;
        logic [1:0] ov;
        logic [SW-1:0] cd0, cd1;
        drive_dispatch(5'd1, 8'h81, 1'b1, got);
        drive_dispatch(5'd2, 8'h82, 1'b1, got);
        drive_commit(2'b11, ov, cd0, cd1);
        tests++; if (cd0 !== expected_commit()) begin fails++; $display("FAIL clr_commit0 got=%h exp=%h", cd0, expected_commit()); end
        void'(sb.pop_front()); m_valid[m_head] = 0; m_head++;
        tests++; if (cd1 !== expected_commit()) begin fails++; $display("FAIL clr_commit1 got=%h exp=%h", cd1, expected_commit()); end
        void'(sb.pop_front()); m_valid[m_head] = 0; m_head++;
        for (int i = 0; i < 4; i++) begin
            drive_dispatch(RW'(i), IW'(8'h90 + i), 1'b1, got);
            tests++; if (got !== N'(i + 2)) begin fails++; $display("FAIL clr_fill_id got=%0d exp=%0d", got, i + 2); end
        end
        @(negedge clk);
        rob_clear = 1;
        #1;
        tests++; if ({i_ready, o_valid} !== 3'b000) begin fails++; $display("FAIL clr_block got=%b exp=000", {i_ready, o_valid}); end
        @(posedge clk);
        #1 rob_clear = 0;
        sb.delete();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_tail = m_head;
        tests++; if (o_count !== 4'd0) begin fails++; $display("FAIL clr_count got=%0d exp=0", o_count); end
        tests++; if (i_rsv_id !== m_head) begin fails++; $display("FAIL clr_tail got=%0d exp=%0d", i_rsv_id, m_head); end
        drive_dispatch(5'd3, 8'hA0, 1'b0, got);
        tests++; if (got !== 3'd2) begin fails++; $display("FAIL clr_next_id got=%0d exp=2", got); end
        $display("[TB] test_rob_clear done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        nrst = 0;
        idle_inputs();
        model_reset();
        #12;
        test_reset();
        test_fill_wrap();
        test_in_order_stall();
        test_partial_commit();
        test_partial_flush();
        test_forwarding();
        test_async_reset();
        test_rob_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reorder_buffer_mp.md
REORDER_BUFFER_MP -- requirements
Module: reorder_buffer_mp

Interface
REQ-001 SHALL have parameter N_ROB_W, default 3, meaning log2 of entry count (depth D = 2**N_ROB_W).
REQ-002 SHALL have parameter ROB_PORT_W, default 6, meaning number of operand read ports.
REQ-003 SHALL have parameter N_CDB, default 2, meaning number of CDB write channels.
REQ-004 SHALL have parameter COMMIT_W, default 2, meaning maximum in-order commits per cycle (1..D).
REQ-005 SHALL use one clock and an asynchronous active-low reset; ports: clk input 1, rising-edge clock; nrst input 1, asynchronous active-low reset.
REQ-006 SHALL have dispatch ports: i_valid in 1; i_ready out 1; i_rsv_id out RSV_ID_W, allocated entry id; i_dst_reg in REG_ADDR_W; i_no_wait in 1, entry ready at allocation; i_opcode in INSTR_W.
REQ-007 SHALL have read ports: rob_id in ROB_PORT_W x RSV_ID_W; rob_data out ROB_PORT_W x (RSV_ID_W+DATA_W), {id, content}; rob_data_filled out ROB_PORT_W.
REQ-008 SHALL have result ports: cdb_valid in N_CDB; cdb in N_CDB x CDB_W, id at [DATA_W+:RSV_ID_W], data at [DATA_W-1:0].
REQ-009 SHALL have flush ports: rob_clear in 1, discard all; flush_valid in 1, partial flush; flush_id in RSV_ID_W, youngest surviving entry.
REQ-010 SHALL have commit ports: o_valid out COMMIT_W; o_commit_data out COMMIT_W x station_t; o_ready in COMMIT_W; o_count out N_ROB_W+1, occupied entries.

Function
REQ-011 SHALL keep head, tail (N_ROB_W bits, wrap D-1 -> 0) and count (0..D); full = (count == D), empty = (count == 0).
REQ-012 SHALL drive i_ready = !full && !rob_clear && !flush_valid; i_rsv_id = tail.
REQ-013 SHALL, on i_valid && i_ready, write entry[tail] = {station_id=tail, valid=1, ready=i_no_wait, dst_reg, opcode, content=0} and advance tail next edge.
REQ-014 SHALL, per CDB channel k with cdb_valid[k] and valid target entry, set ready=1 and content=data next edge; writes to invalid entries are dropped; two channels same id in one cycle: highest k wins.
REQ-015 SHALL drive read port outputs combinationally: {rob_id[i], entry content}, filled = entry ready; if a same-cycle CDB write targets rob_id[i], forward CDB data and filled=1.
REQ-016 SHALL drive o_valid[k] = entry[head+k] valid && ready && o_valid[k-1] (k>0) && k < count, forced 0 while rob_clear or flush_valid; o_commit_data[k] = entry[head+k].
REQ-017 SHALL commit slot k only when o_valid[j] && o_ready[j] for all j<=k; committed entries zeroed, head += number committed (mod D).
REQ-018 SHALL update count = count + dispatched - committed each cycle; dispatch and commit in the same cycle while full are legal only if commit frees a slot first is NOT assumed: full blocks dispatch regardless.
REQ-019 SHALL, on rob_clear, invalidate all entries, set tail = head, count = 0 next edge; rob_clear overrides flush_valid, dispatch, CDB, commit.
REQ-020 SHALL, on flush_valid with valid entry[flush_id], invalidate entries strictly younger than flush_id, set tail = flush_id+1 (mod D), count = ((flush_id - head) mod D) + 1; CDB writes to surviving entries that cycle still apply.
REQ-021 SHALL ignore flush_valid when entry[flush_id] is invalid (no state change from flush).
REQ-022 SHALL register all state on clk rising edge; no combinational path from o_ready to i_ready.

Reset
REQ-023 SHALL, while nrst=0 (asynchronous), clear all entries to 0, head = tail = 0, count = 0; outputs: o_valid = 0, i_ready = 1, i_rsv_id = 0, o_count = 0, rob_data_filled reflects zeroed entries.
REQ-024 SHALL resume normal operation on the first rising edge after nrst deasserts; reset mid-operation discards all in-flight entries.

Verification (N_ROB_W=3, COMMIT_W=2, N_CDB=2)
REQ-025 SHALL cover fill/wrap: dispatch 8 with i_no_wait=0 -> ids 0..7, i_ready=0, o_count=8; CDB id0,id1 then commit both in one cycle -> head=2, o_count=6, next dispatch gets id 0.
REQ-026 SHALL cover in-order stall: ids 0,1 allocated, CDB completes id1 only -> o_valid=2'b00; then id0 -> o_valid=2'b11.
REQ-027 SHALL cover partial commit: both ready, o_ready=2'b10 -> nothing commits; o_ready=2'b01 -> only id0 commits, head=1.
REQ-028 SHALL cover partial flush: ids 0..5 allocated, flush_id=2 -> tail=3, o_count=3, late CDB to id4 dropped, next dispatch gets id 3.
REQ-029 SHALL cover forwarding/collision: cdb ch0 and ch1 both target id3 with 0xA/0xB while rob_id[0]=3 -> rob_data[0]={3,0xB}, filled=1; stored content 0xB.
REQ-030 SHALL cover async reset: nrst low mid-cycle with count=5 -> o_count=0, o_valid=0 immediately without clock edge; rob_clear with count=4 -> count=0, tail=head.
